// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and selectable standard/FWFT read.
module sync_fifo_ext #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          FWFT       = 1'b0,
    parameter int unsigned AF_THR     = FIFO_DEPTH - 2,
    parameter int unsigned AE_THR     = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          rd_en,
    output logic [DATA_WIDTH-1:0]         rd_data,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow,
    input  logic                          clr_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_acc, rd_acc;

    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_THR));
    assign almost_empty = (count_q <= CW'(AE_THR));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Acceptance uses pre-edge flags: a full FIFO still pops, an empty one still pushes.
    always_comb begin
        wr_acc   = wr_en & ~full;
        rd_acc   = rd_en & ~empty;
        wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);

        overflow_d = overflow_q;
        if (wr_en & full) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end

        underflow_d = underflow_q;
        if (rd_en & empty) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is shown directly; a write to an empty FIFO is visible after its edge.
            assign rd_data = mem[rd_ptr_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

            always_comb begin
                rd_data_d = rd_data_q;
                if (rd_acc) begin
                    rd_data_d = mem[rd_ptr_q];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end

            assign rd_data = rd_data_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Scoreboard bench for sync_fifo_ext: a standard-mode instance checked every cycle
// against a queue model, plus an FWFT instance with directed checks.
module tb_sync_fifo_ext;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] wr_data = '0;
    logic [7:0] rd_data;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       f_wr_en = 1'b0, f_rd_en = 1'b0, f_clr_err = 1'b0;
    logic [7:0] f_wr_data = '0;
    logic [7:0] f_rd_data;
    logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
    logic [4:0] f_count;

    int unsigned total = 0;
    int unsigned bad   = 0;

    logic [7:0] sb [$];
    logic [7:0] rd_last = '0;
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .rd_data(rd_data), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_ext #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .full(f_full), .empty(f_empty), .almost_full(f_almost_full),
        .almost_empty(f_almost_empty), .count(f_count), .overflow(f_overflow),
        .underflow(f_underflow), .clr_err(f_clr_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_status(input string tag);
        int unsigned n;
        n = sb.size();
        check({tag, ".count"}, 32'(count), n);
        check({tag, ".full"}, 32'(full), 32'(n == 16));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".af"}, 32'(almost_full), 32'(n >= 14));
        check({tag, ".ae"}, 32'(almost_empty), 32'(n <= 2));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, ".udf"}, 32'(underflow), 32'(m_udf));
        check({tag, ".rd_data"}, 32'(rd_data), 32'(rd_last));
    endtask

    // One clock of the standard instance: model updated from pre-edge state, DUT sampled 1ns after the edge.
    task automatic step(input string tag, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        logic mfull, mempty, wacc, racc;
        wr_en = w; wr_data = d; rd_en = r; clr_err = c;
        mfull  = (sb.size() == 16);
        mempty = (sb.size() == 0);
        wacc   = w & ~mfull;
        racc   = r & ~mempty;
        if (racc) rd_last = sb.pop_front();
        if (wacc) sb.push_back(d);
        if (w & mfull) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
        if (r & mempty) m_udf = 1'b1; else if (c) m_udf = 1'b0;
        @(posedge clk);
        #1;
        check_status(tag);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
    endtask

    initial begin
        #2;
        check_status("reset");
        check("f_reset.empty", 32'(f_empty), 32'd1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
        step("wr_full", 1'b1, 8'hAA, 1'b0, 1'b0);
        step("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);

        step("rd_empty", 1'b0, 8'h00, 1'b1, 1'b0);
        step("clr_udf", 1'b0, 8'h00, 1'b0, 1'b1);
        step("clr_vs_set", 1'b0, 8'h00, 1'b1, 1'b1);
        step("clr_udf2", 1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 5; i++) step("pre5", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step("wr_rd_5", 1'b1, 8'(8'h80 + i), 1'b1, 1'b0);

        for (int i = 0; i < 11; i++) step("fill2", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step("full_wr_rd", 1'b1, 8'hEE, 1'b1, 1'b0);
        step("clr_ovf2", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 15; i++) step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        step("empty_wr_rd", 1'b1, 8'h5B, 1'b1, 1'b0);
        step("clr_udf3", 1'b0, 8'h00, 1'b0, 1'b1);
        step("rd_single", 1'b0, 8'h00, 1'b1, 1'b0);

        // Reset lands between edges, halfway through a 10-word burst.
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                wr_en = 1'b0; rd_en = 1'b0;
                #2 rst_n = 1'b0;
                sb.delete();
                rd_last = '0; m_ovf = 1'b0; m_udf = 1'b0;
                #1;
                check_status("mid_reset");
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk); #1;
            end else begin
                step("burst", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            end
        end
        step("post_rst_wr", 1'b1, 8'h77, 1'b0, 1'b0);
        step("post_rst_wr", 1'b1, 8'h78, 1'b0, 1'b0);
        step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

        // FWFT instance
        f_wr_en = 1'b1; f_wr_data = 8'h5A;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        check("fwft_first.empty", 32'(f_empty), 32'd0);
        check("fwft_first.data", 32'(f_rd_data), 32'h5A);
        check("fwft_first.count", 32'(f_count), 32'd1);
        f_wr_en = 1'b1; f_wr_data = 8'h3C;
        @(posedge clk); #1;
        f_wr_en = 1'b0;
        check("fwft_second.data", 32'(f_rd_data), 32'h5A);
        check("fwft_second.count", 32'(f_count), 32'd2);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        check("fwft_pop.data", 32'(f_rd_data), 32'h3C);
        check("fwft_pop.count", 32'(f_count), 32'd1);
        f_rd_en = 1'b1;
        @(posedge clk); #1;
        f_rd_en = 1'b0;
        check("fwft_last.empty", 32'(f_empty), 32'd1);
        check("fwft_last.udf", 32'(f_underflow), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised single-clock FIFO, successor to the basic synchronous FIFO. Adds:
- occupancy count output
- programmable almost-full and almost-empty flags
- sticky overflow and underflow error flags with a clear input
- selectable standard or first-word-fall-through (FWFT) read mode
- exact count accounting on simultaneous read/write, including rejected operations

Used as the general buffering primitive between producer and consumer blocks in the same clock domain.

Parameters:
DATA_WIDTH, 8, width of each data word
FIFO_DEPTH, 16, number of entries; power of two, >= 2
FWFT, 0, 0 = standard read (rd_data registered 1 cycle after rd_en); 1 = head word presented on rd_data while not empty
AF_THR, FIFO_DEPTH-2, almost_full asserted when count >= AF_THR
AE_THR, 2, almost_empty asserted when count <= AE_THR

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write data
rd_en  in  1  read (pop) request
rd_data  out  DATA_WIDTH  read data
full  out  1  count == FIFO_DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THR
almost_empty  out  1  count <= AE_THR
count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
clr_err  in  1  synchronous clear of overflow/underflow

Behaviour:
- Reset: rd_ptr, wr_ptr, count, rd_data, overflow and underflow all go to 0 immediately. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- Reset mid-operation discards all stored data; the first post-reset write behaves as a write to an empty FIFO.
- Acceptance:
  - wr_acc = wr_en & !full
  - rd_acc = rd_en & !empty
  - Both are evaluated on pre-edge state.
- Pointers:
  - $clog2(FIFO_DEPTH) bits wide; wrap naturally from FIFO_DEPTH-1 to 0.
  - wr_ptr increments on wr_acc; rd_ptr increments on rd_acc.
- Count:
  - count_next = count + wr_acc - rd_acc, applied on every cycle.
  - Both accepted: count unchanged.
  - One request rejected: only the accepted side counts.
- Full plus both requests: read accepted, write rejected, overflow set, count decrements.
- Empty plus both requests: write accepted, read rejected, underflow set, count increments. No write-to-read bypass.
- Flags full, empty, almost_full and almost_empty are combinational from registered count and reflect the post-edge count.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr]; valid the cycle after the rd_en edge.
  - rd_data holds its value when there is no rd_acc.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] whenever empty=0; rd_acc advances to the next word.
  - A write into an empty FIFO at edge N makes the word visible on rd_data after edge N, with empty=0 in the same cycle.
  - rd_data is don't-care while empty=1.
- Errors:
  - overflow set on any edge with wr_en & full.
  - underflow set on any edge with rd_en & empty.
  - Both are sticky until clr_err=1 at an edge.
  - If clr_err coincides with a new error event, the set wins.
  - Rejected operations never modify memory, pointers or count.

Test Plan:
- Reset, then 16 writes 0x00..0x0F (FWFT=0): count=16, full=1, almost_full from count 14. 17th write 0xAA: overflow=1, count=16. Drain 16 reads: data 0x00..0x0F in order, 1-cycle latency, empty=1 at end.
- Read while empty: underflow=1, count stays 0, rd_data holds. Assert clr_err: underflow=0 next cycle. clr_err together with a new rd_en while empty: underflow stays 1.
- At count=5, simultaneous wr/rd for 20 cycles: count stays 5, pointers wrap, output order preserved.
- At full, wr_en & rd_en: count 16 -> 15, overflow=1, read returns the oldest word. At empty, wr_en & rd_en: count 0 -> 1, underflow=1.
- FWFT=1: write 0x5A into empty FIFO; the cycle after, empty=0 and rd_data=0x5A without rd_en. Write 0x3C, then pulse rd_en: rd_data=0x3C.
- Write 10 words, assert rst_n=0 mid-burst: empty=1, count=0 and flags cleared immediately. Resume: the first word read is the first post-reset write.
